// File: rtl/hard_pkg.sv
// Shared types and constants for the hard FIR load path.
package hard_pkg;

    // Top-level load sequence states
    typedef enum logic [2:0] {
        IDLE,
        RST,
        COEFF,
        SCALE,
        STREAM
    } load_state_t;

    // Per-word strobe sub-phase
    typedef enum logic [1:0] {
        WAIT,
        SETUP,
        HIGH
    } stb_phase_t;

    // Q.11 fixed point, shared with the filter and its models
    localparam int FRAC_BITS = 11;

    // Strobe/ready line indices on the strobe generator
    localparam int LINE_CFG = 0;
    localparam int LINE_SMP = 1;

    // States in which the loader takes words from one of its input streams
    function automatic logic accepts_words(input load_state_t s);
        return (s == COEFF) || (s == SCALE) || (s == STREAM);
    endfunction

endpackage

// File: rtl/hard_strobe_gen.sv
// WAIT/SETUP/HIGH phase machine: registers one word, presents it for a cycle,
// pulses the selected strobe line, then holds the word one more cycle.
module hard_strobe_gen
    import hard_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              line_i,
    input  logic              go_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] filt_in_o,
    output logic [1:0]        strobe_o,
    output logic [1:0]        ready_o
);

    stb_phase_t        phase_q;
    logic              line_q;
    logic [DATA_W-1:0] filt_in_q;
    logic [1:0]        strobe_q;
    logic [1:0]        ready_q;

    // One-hot line select: bit 0 = cfg side, bit 1 = sample side
    function automatic logic [1:0] sel(input logic line);
        return {line, ~line};
    endfunction

    // Phase sequencing; clr_i drops any word in flight without strobing it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= WAIT;
            line_q    <= 1'b0;
            filt_in_q <= '0;
            strobe_q  <= '0;
            ready_q   <= '0;
        end else if (clr_i) begin
            phase_q  <= WAIT;
            line_q   <= 1'b0;
            strobe_q <= '0;
            ready_q  <= '0;
        end else begin
            case (phase_q)
                WAIT: begin
                    if (go_i) begin
                        filt_in_q <= word_i;
                        line_q    <= ready_q[LINE_SMP];
                        ready_q   <= '0;
                        phase_q   <= SETUP;
                    end else begin
                        ready_q <= en_i ? sel(line_i) : 2'b00;
                    end
                end
                SETUP: begin
                    strobe_q <= sel(line_q);
                    phase_q  <= HIGH;
                end
                HIGH: begin
                    strobe_q <= '0;
                    ready_q  <= en_i ? sel(line_i) : 2'b00;
                    phase_q  <= WAIT;
                end
                default: begin
                    strobe_q <= '0;
                    ready_q  <= '0;
                    phase_q  <= WAIT;
                end
            endcase
        end
    end

    assign filt_in_o = filt_in_q;
    assign strobe_o  = strobe_q;
    assign ready_o   = ready_q;

endmodule

// File: rtl/hard_loader.sv
// Load-side sequencer for the hard FIR filter: reset pulse, TAPS coefficients,
// one scale word, then an unbounded sample stream.
module hard_loader #(
    parameter int TAPS    = 64,
    parameter int DATA_W  = 32,
    parameter int RST_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              smp_valid,
    output logic              smp_ready,
    input  logic [DATA_W-1:0] smp_data,
    output logic              filt_reset,
    output logic              filt_coeff_stb,
    output logic              filt_sample_stb,
    output logic [DATA_W-1:0] filt_in,
    output logic              busy,
    output logic              window_full
);
    import hard_pkg::*;

    localparam int RW = $clog2(RST_CYC + 1);
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int SW = $clog2(TAPS + 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYC - 1);
    localparam logic [CW-1:0] COEFF_LAST = CW'(TAPS - 1);
    localparam logic [SW-1:0] SMP_LAST   = SW'(TAPS - 1);
    localparam logic [SW-1:0] SMP_FULL   = SW'(TAPS);

    load_state_t   state_q, state_d;
    logic [RW-1:0] rst_cnt_q;
    logic [CW-1:0] coeff_cnt_q;
    logic [SW-1:0] smp_cnt_q;
    logic          window_full_q;
    logic          filt_reset_q;
    logic          busy_q;

    logic [1:0]        stb;
    logic [1:0]        rdy;
    logic [DATA_W-1:0] word;
    logic              go;

    // start beats any handshake in the same cycle
    assign go   = ~start & ((cfg_valid & rdy[LINE_CFG]) | (smp_valid & rdy[LINE_SMP]));
    assign word = rdy[LINE_SMP] ? smp_data : cfg_data;

    // Next load state; strobe HIGH cycles retire words
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RST;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RST:     if (rst_cnt_q == RST_LAST) state_d = COEFF;
                COEFF:   if (stb[LINE_CFG] && (coeff_cnt_q == COEFF_LAST)) state_d = SCALE;
                SCALE:   if (stb[LINE_CFG]) state_d = STREAM;
                STREAM:  state_d = STREAM;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            coeff_cnt_q   <= '0;
            smp_cnt_q     <= '0;
            window_full_q <= 1'b0;
            filt_reset_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= !((state_d == IDLE) || (state_d == STREAM));
            filt_reset_q <= (state_d == RST);
            if (start) begin
                rst_cnt_q     <= '0;
                coeff_cnt_q   <= '0;
                smp_cnt_q     <= '0;
                window_full_q <= 1'b0;
            end else begin
                case (state_q)
                    RST: begin
                        rst_cnt_q <= (rst_cnt_q == RST_LAST) ? '0 : rst_cnt_q + 1'b1;
                    end
                    COEFF: begin
                        if (stb[LINE_CFG] && (coeff_cnt_q != COEFF_LAST))
                            coeff_cnt_q <= coeff_cnt_q + 1'b1;
                    end
                    STREAM: begin
                        if (stb[LINE_SMP] && (smp_cnt_q != SMP_FULL)) begin
                            smp_cnt_q <= smp_cnt_q + 1'b1;
                            if (smp_cnt_q == SMP_LAST) window_full_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    hard_strobe_gen #(
        .DATA_W(DATA_W)
    ) u_stb (
        .clk       (clk),
        .rst       (reset),
        .clr_i     (start),
        .en_i      (accepts_words(state_d)),
        .line_i    (state_d == STREAM),
        .go_i      (go),
        .word_i    (word),
        .filt_in_o (filt_in),
        .strobe_o  (stb),
        .ready_o   (rdy)
    );

    assign cfg_ready       = rdy[LINE_CFG];
    assign smp_ready       = rdy[LINE_SMP];
    assign filt_coeff_stb  = stb[LINE_CFG];
    assign filt_sample_stb = stb[LINE_SMP];
    assign filt_reset      = filt_reset_q;
    assign busy            = busy_q;
    assign window_full     = window_full_q;

endmodule

// File: tb/tb_hard_loader.sv
// Scoreboard bench for hard_loader: stimulus pushes expected strobed words,
// a negedge monitor pops and checks them along with strobe timing rules.
module tb_hard_loader;
    import hard_pkg::*;

    localparam int TAPS    = 64;
    localparam int DATA_W  = 32;
    localparam int RST_CYC = 2;

    logic              clk = 1'b0;
    logic              reset, start, cfg_valid, smp_valid;
    logic [DATA_W-1:0] cfg_data, smp_data;
    logic              cfg_ready, smp_ready, filt_reset, filt_coeff_stb, filt_sample_stb;
    logic [DATA_W-1:0] filt_in;
    logic              busy, window_full;

    always #5 clk = ~clk;

    hard_loader #(.TAPS(TAPS), .DATA_W(DATA_W), .RST_CYC(RST_CYC)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
        .filt_reset(filt_reset), .filt_coeff_stb(filt_coeff_stb),
        .filt_sample_stb(filt_sample_stb), .filt_in(filt_in),
        .busy(busy), .window_full(window_full)
    );

    typedef struct packed {
        logic              smp;
        logic [DATA_W-1:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   hs_cnt = 0, stb_cnt = 0, discarded = 0;
    int   coeff_since = 0, smp_since = 0;
    logic [DATA_W-1:0] coef_cap [0:TAPS];
    logic [DATA_W-1:0] smp_cap  [0:TAPS-1];
    logic [DATA_W-1:0] prev_in = '0;
    logic prev_stb = 1'b0, prev_smp_stb = 1'b0, prev_rst = 1'b0;
    int   rst_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every strobe, plus setup/hold and reset pulse length
    always @(negedge clk) begin
        logic cs, ss;
        exp_t e;
        if (!reset) begin
            cs = filt_coeff_stb;
            ss = filt_sample_stb;
            if (cs || ss) begin
                stb_cnt++;
                chk("strobe_exclusive", {63'd0, cs & ss}, 0);
                chk("strobe_in_reset", {63'd0, filt_reset}, 0);
                chk("sb_nonempty", {63'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("strobe_line", {63'd0, ss}, {63'd0, e.smp});
                    chk("filt_in", filt_in, e.w);
                end
                chk("setup", filt_in, prev_in);
                if (cs) begin
                    if (coeff_since <= TAPS) coef_cap[coeff_since] = filt_in;
                    coeff_since++;
                end
                if (ss) begin
                    chk("window_full_at_strobe", {63'd0, window_full}, {63'd0, smp_since >= TAPS});
                    if (smp_since < TAPS) smp_cap[smp_since] = filt_in;
                    smp_since++;
                end
            end
            if (prev_stb) chk("hold", filt_in, prev_in);
            if (prev_smp_stb && smp_since == TAPS) chk("window_full_rise", {63'd0, window_full}, 1);
            if (filt_reset) rst_run++;
            else if (prev_rst) begin
                chk("rst_len", rst_run, RST_CYC);
                rst_run = 0;
            end
            prev_in      = filt_in;
            prev_stb     = cs | ss;
            prev_smp_stb = ss;
            prev_rst     = filt_reset;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; the handshake is decided at the negedge before the accepting edge
    task automatic send(input bit smp, input logic [DATA_W-1:0] w, input bit toggle);
        bit v, hs;
        v  = !toggle;
        hs = 1'b0;
        if (smp) smp_data = w; else cfg_data = w;
        for (int n = 0; n < 100 && !hs; n++) begin
            if (smp) smp_valid = v; else cfg_valid = v;
            @(negedge clk);
            hs = v && (smp ? smp_ready : cfg_ready);
            @(posedge clk);
            #1;
            if (toggle) v = !v;
        end
        cfg_valid = 1'b0;
        smp_valid = 1'b0;
        if (hs) begin
            exp_q.push_back('{smp: smp, w: w});
            hs_cnt++;
        end else begin
            chk("handshake_timeout", {63'd0, hs}, 1);
        end
    endtask

    task automatic do_start();
        align();
        start       = 1'b1;
        coeff_since = 0;
        smp_since   = 0;
        align();
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        longint acc_dut, acc_ref, out_dut, out_ref;
        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; smp_valid = 1'b0;
        cfg_data = '0; smp_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_filt_reset", {63'd0, filt_reset}, 0);
        chk("rst_coeff_stb", {63'd0, filt_coeff_stb}, 0);
        chk("rst_sample_stb", {63'd0, filt_sample_stb}, 0);
        chk("rst_filt_in", filt_in, 0);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_window_full", {63'd0, window_full}, 0);
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 0);
        chk("rst_smp_ready", {63'd0, smp_ready}, 0);

        // Samples offered before any start are ignored
        align();
        smp_valid = 1'b1;
        smp_data  = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_smp_ready", {63'd0, smp_ready}, 0);
        end
        align();
        smp_valid = 1'b0;

        // Full load: 64 coefficients i*16, scale 0x200
        do_start();
        @(negedge clk);
        chk("load_busy", {63'd0, busy}, 1);
        chk("load_filt_reset", {63'd0, filt_reset}, 1);
        align();
        for (int i = 0; i < TAPS; i++) send(1'b0, DATA_W'(i * 16), 1'b0);
        send(1'b0, 32'h200, 1'b0);
        drain();
        chk("load_coeff_strobes", coeff_since, TAPS + 1);
        chk("stream_busy", {63'd0, busy}, 0);
        chk("stream_cfg_ready", {63'd0, cfg_ready}, 0);
        chk("stream_smp_ready", {63'd0, smp_ready}, 1);
        align();

        // 64 unit samples fill the window, two more show saturation
        for (int i = 0; i < TAPS + 2; i++) send(1'b1, 32'd1, 1'b0);
        drain();
        chk("window_full_after", {63'd0, window_full}, 1);
        chk("sample_strobes", smp_since, TAPS + 2);

        acc_dut = 0;
        acc_ref = 0;
        for (int i = 0; i < TAPS; i++) begin
            acc_dut += longint'($signed(coef_cap[i])) * longint'($signed(smp_cap[i]));
            acc_ref += longint'(i * 16);
        end
        out_dut = (acc_dut * longint'($signed(coef_cap[TAPS]))) >>> (2 * FRAC_BITS);
        out_ref = (acc_ref * 64'sh200) >>> (2 * FRAC_BITS);
        chk("model_out", out_dut, out_ref);

        // Collision: start and a sample handshake in the same cycle
        align();
        for (int n = 0; n < 20 && !smp_ready; n++) @(negedge clk);
        @(negedge clk);
        start       = 1'b1;
        smp_valid   = 1'b1;
        smp_data    = 32'd9;
        coeff_since = 0;
        smp_since   = 0;
        align();
        start     = 1'b0;
        smp_valid = 1'b0;
        @(negedge clk);
        chk("collision_window_full", {63'd0, window_full}, 0);
        chk("collision_smp_ready", {63'd0, smp_ready}, 0);
        chk("collision_filt_reset", {63'd0, filt_reset}, 1);
        align();

        // Back-pressure reload with valid toggling every other cycle
        for (int i = 0; i < TAPS; i++) send(1'b0, DATA_W'(i * 16 + 5), 1'b1);
        send(1'b0, 32'h180, 1'b1);
        align();
        for (int i = 0; i < 4; i++) send(1'b1, 32'hFFFF_FFF0 + DATA_W'(i), 1'b1);
        drain();
        chk("bp_coeff_strobes", coeff_since, TAPS + 1);
        chk("bp_sample_strobes", smp_since, 4);

        // Abort during coefficient #30 SETUP
        do_start();
        for (int i = 0; i < 30; i++) send(1'b0, DATA_W'(i * 16), 1'b0);
        send(1'b0, DATA_W'(30 * 16), 1'b0);
        start = 1'b1;
        void'(exp_q.pop_back());
        discarded++;
        align();
        start = 1'b0;
        @(negedge clk);
        chk("abort_no_strobe", {63'd0, filt_coeff_stb}, 0);
        chk("abort_filt_reset", {63'd0, filt_reset}, 1);
        repeat (3) @(negedge clk);
        chk("abort_coeffs", coeff_since, 30);
        coeff_since = 0;
        smp_since   = 0;
        align();
        for (int i = 0; i < TAPS; i++) send(1'b0, DATA_W'(i * 16 + 1), 1'b0);
        send(1'b0, 32'h200, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, DATA_W'(100 + i), 1'b0);
        drain();
        chk("reload_coeff_strobes", coeff_since, TAPS + 1);
        chk("reload_sample_strobes", smp_since, 3);

        chk("sb_empty", exp_q.size(), 0);
        chk("strobes_vs_handshakes", stb_cnt, hs_cnt - discarded);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
